// File: rtl/alu_result_stage_if.sv
// ---------------------------------------------------------------------------
// alu_result_stage_if
//   Bundle of the ALU-side input handshake, the writeback-side output
//   handshake and the completed-operation counter of alu_result_stage.
//
//   Parameters
//     WIDTH  data width of the ALU result
//     OPW    opcode tag width
//     CNT_W  width of the completed-operation counter
//
//   Signals
//     in_valid / in_ready            ALU -> stage handshake
//     data_result, isNotEqual,
//     isLessThan, overflow,
//     ctrl_ALUopcode                 payload offered by the ALU
//     out_valid / out_ready          stage -> writeback handshake
//     out_result, out_isNotEqual,
//     out_isLessThan, out_overflow,
//     out_opcode                     registered payload towards writeback
//     op_count                       number of output handshakes completed
//
//   Modports
//     master  environment view (drives ALU payload and out_ready)
//     slave   stage view (alu_result_stage)
// ---------------------------------------------------------------------------
interface alu_result_stage_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_result;
    logic             isNotEqual;
    logic             isLessThan;
    logic             overflow;
    logic [OPW-1:0]   ctrl_ALUopcode;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_isNotEqual;
    logic             out_isLessThan;
    logic             out_overflow;
    logic [OPW-1:0]   out_opcode;

    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid,
        output data_result,
        output isNotEqual,
        output isLessThan,
        output overflow,
        output ctrl_ALUopcode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_isNotEqual,
        input  out_isLessThan,
        input  out_overflow,
        input  out_opcode,
        input  op_count
    );

    modport slave (
        input  in_valid,
        input  data_result,
        input  isNotEqual,
        input  isLessThan,
        input  overflow,
        input  ctrl_ALUopcode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output out_isNotEqual,
        output out_isLessThan,
        output out_overflow,
        output out_opcode,
        output op_count
    );
endinterface

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//   Registered output stage behind the ALU datapath. Captures the ALU result,
//   its flags and opcode tag and hands them to writeback over valid/ready.
//   A two-entry skid buffer (main register M, skid register S) keeps in_ready
//   a pure flop output, so out_ready never reaches the ALU combinationally.
//
//   Ports
//     clock       rising-edge clock
//     reset_n     asynchronous active-low reset
//     bus         alu_result_stage_if.slave (both handshakes, payloads,
//                 op_count)
//     clear_ovf   (optional) clears sticky_ovf on the next edge
//     sticky_ovf  (optional) set after any output handshake carrying
//                 overflow=1; set wins over a simultaneous clear
//
//   Optional feature macro: ALU_RESULT_STICKY_OVF_EN
//     undefined (default): no clear_ovf / sticky_ovf ports, no sticky logic
//     defined            : adds the sticky overflow flag
//
//   Buffer state is the pair {M_v,S_v}:
//     EMPTY 2'b00, HALF 2'b10, FULL 2'b11 (2'b01 is unreachable).
// ---------------------------------------------------------------------------
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5,
    parameter int CNT_W = 16
) (
    input  logic clock,
    input  logic reset_n,
`ifdef ALU_RESULT_STICKY_OVF_EN
    input  logic clear_ovf,
    output logic sticky_ovf,
`endif
    alu_result_stage_if.slave bus
);

    // Payload layout: {result, isNotEqual, isLessThan, overflow, opcode}
    localparam int PW      = WIDTH + 3 + OPW;
    localparam int OVF_BIT = OPW;
    localparam int LT_BIT  = OPW + 1;
    localparam int NE_BIT  = OPW + 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HALF  = 2'b10,
        ST_FULL  = 2'b11
    } state_e;

    state_e          state_r;
    state_e          state_nxt_s;
    logic            in_ready_r;
    logic [PW-1:0]   m_payload_r;
    logic [PW-1:0]   s_payload_r;
    logic [PW-1:0]   in_payload_s;
    logic [CNT_W-1:0] op_count_r;

    logic            m_v_s;
    logic            in_hs_s;
    logic            out_hs_s;
    logic            load_m_in_s;
    logic            load_m_skid_s;
    logic            load_s_s;

    assign in_payload_s = {bus.data_result, bus.isNotEqual, bus.isLessThan,
                           bus.overflow, bus.ctrl_ALUopcode};

    // M_v is the upper state bit, so out_valid comes straight from a flop
    assign m_v_s    = state_r[1];
    assign in_hs_s  = bus.in_valid & in_ready_r;
    assign out_hs_s = m_v_s & bus.out_ready;

    // State register; in_ready is re-registered from the next S_v
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_EMPTY;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= ~state_nxt_s[0];
        end
    end

    // Next-state decode of the skid buffer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (in_hs_s) begin
                    state_nxt_s = ST_HALF;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_HALF: begin
                if (in_hs_s && !out_hs_s) begin
                    state_nxt_s = ST_FULL;
                end else if (out_hs_s && !in_hs_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_HALF;
                end
            end
            ST_FULL: begin
                if (out_hs_s) begin
                    state_nxt_s = ST_HALF;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // Datapath load enables derived from the current state and handshakes
    always_comb begin
        load_m_in_s   = 1'b0;
        load_m_skid_s = 1'b0;
        load_s_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                load_m_in_s = in_hs_s;
            end
            ST_HALF: begin
                // Simultaneous in/out replaces M; input alone parks in S
                load_m_in_s = in_hs_s & out_hs_s;
                load_s_s    = in_hs_s & ~out_hs_s;
            end
            ST_FULL: begin
                // in_ready is low here, so only the skid entry can move up
                load_m_skid_s = out_hs_s;
            end
            default: begin
                load_m_in_s   = 1'b0;
                load_m_skid_s = 1'b0;
                load_s_s      = 1'b0;
            end
        endcase
    end

    // Payload registers; contents are kept after dequeue, only loads change them
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_payload_r <= {PW{1'b0}};
            s_payload_r <= {PW{1'b0}};
        end else begin
            if (load_m_in_s) begin
                m_payload_r <= in_payload_s;
            end else if (load_m_skid_s) begin
                m_payload_r <= s_payload_r;
            end else begin
                m_payload_r <= m_payload_r;
            end
            if (load_s_s) begin
                s_payload_r <= in_payload_s;
            end else begin
                s_payload_r <= s_payload_r;
            end
        end
    end

    // Completed-operation counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_count_r <= {CNT_W{1'b0}};
        end else if (out_hs_s) begin
            op_count_r <= op_count_r + CNT_W'(1);
        end else begin
            op_count_r <= op_count_r;
        end
    end

`ifdef ALU_RESULT_STICKY_OVF_EN
    logic sticky_ovf_r;

    // Sticky overflow: a handshake carrying overflow beats a same-cycle clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sticky_ovf_r <= 1'b0;
        end else if (out_hs_s && m_payload_r[OVF_BIT]) begin
            sticky_ovf_r <= 1'b1;
        end else if (clear_ovf) begin
            sticky_ovf_r <= 1'b0;
        end else begin
            sticky_ovf_r <= sticky_ovf_r;
        end
    end

    assign sticky_ovf = sticky_ovf_r;
`endif

    assign bus.in_ready       = in_ready_r;
    assign bus.out_valid      = m_v_s;
    assign bus.out_result     = m_payload_r[PW-1:NE_BIT+1];
    assign bus.out_isNotEqual = m_payload_r[NE_BIT];
    assign bus.out_isLessThan = m_payload_r[LT_BIT];
    assign bus.out_overflow   = m_payload_r[OVF_BIT];
    assign bus.out_opcode     = m_payload_r[OPW-1:0];
    assign bus.op_count       = op_count_r;

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the ALU datapath (shifter, adder, logic units).
- Captures the 32-bit ALU result, its comparison/overflow flags and its opcode tag.
- Presents them to the writeback consumer over a valid/ready handshake.
- Uses a 2-entry skid buffer, so in_ready is fully registered and the ALU never sees a combinational path from out_ready.

Parameters:
- WIDTH, 32, data width of result
- OPW, 5, opcode tag width (matches ctrl_ALUopcode)
- CNT_W, 16, width of completed-operation counter

Ports:
- clock  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  ALU result valid this cycle
- in_ready  output  1  stage can accept; registered
- data_result  input  WIDTH  ALU result (sll/sra/add/sub/and/or)
- isNotEqual  input  1  ALU flag
- isLessThan  input  1  ALU flag
- overflow  input  1  ALU flag
- ctrl_ALUopcode  input  OPW  opcode that produced the result
- out_valid  output  1  output entry valid
- out_ready  input  1  consumer accepts
- out_result  output  WIDTH  registered result
- out_isNotEqual  output  1  registered flag
- out_isLessThan  output  1  registered flag
- out_overflow  output  1  registered flag
- out_opcode  output  OPW  registered opcode
- op_count  output  CNT_W  number of output handshakes completed

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clock, reset_n).
- Reset values:
  - out_valid=0, in_ready=1, op_count=0.
  - All out_* data/flag/opcode registers = 0; skid entry cleared.
- Payload: {data_result, isNotEqual, isLessThan, overflow, ctrl_ALUopcode}, moved as one unit; never reordered.
- Storage: main register M (drives out_*) and skid register S; flags M_v, S_v.
- Handshakes:
  - Input handshake: in_valid & in_ready.
  - Output handshake: out_valid & out_ready.
  - out_valid = M_v; in_ready = ~S_v (a register, no combinational path from out_ready).
- States, encoded by {M_v,S_v}:
  - EMPTY (00): input handshake -> load M, go HALF (10).
  - HALF (10):
    - input only -> load S, go FULL.
    - output only -> go EMPTY.
    - both -> load M with new payload, stay HALF.
    - neither -> hold.
  - FULL (11), in_ready=0:
    - output handshake -> M<=S, S_v<=0, go HALF.
    - otherwise hold.
    - in_valid ignored.
- Latency: 1 cycle from input handshake to out_valid when EMPTY; throughput 1 per cycle while out_ready held high.
- Data stability: out_* stable while out_valid=1 and out_ready=0. Payload bits are not cleared on dequeue; they hold their last value.
- op_count:
  - Increments by 1 on each output handshake.
  - Wraps from 2^CNT_W-1 to 0 with no saturation.
- Reset mid-operation: any buffered entries are discarded immediately and asynchronously; outputs return to reset values.
- Not permitted: X on in_valid; no other input constraints.

Optional Feature:
- Macro: ALU_RESULT_STICKY_OVF_EN.
- Defined:
  - Adds input clear_ovf (1) and output sticky_ovf (1), reset 0.
  - sticky_ovf sets on the cycle after any output handshake whose out_overflow=1.
  - clear_ovf=1 clears it next edge.
  - Simultaneous set and clear -> set wins.
- Undefined: neither port exists; no sticky logic.

Test Plan:
- Reset, then one input handshake of data_result=32'h0000_0010, ctrl_ALUopcode=5'b00011, out_ready=1 -> out_valid=1 next cycle with out_result=32'h10, out_opcode=3; op_count=1 after the following edge.
- Hold out_ready=0, push A=32'h1, B=32'h2 -> after the second push in_ready=0 and out_result=1. Third push C is ignored. Raise out_ready -> outputs A, then B, with no C; op_count=2.
- Stream 8 consecutive results 0..7 with out_ready=1 -> out_valid held high 8 consecutive cycles, results 0..7 in order, in_ready never drops.
- Preload op_count to 16'hFFFF via 65535 handshakes (or a force), then one more handshake -> op_count=0.
- FULL with entries pending, assert reset_n=0 mid-cycle -> out_valid=0, in_ready=1, op_count=0 immediately (before the next clock edge).
- With ALU_RESULT_STICKY_OVF_EN: push overflow=1 then overflow=0 -> sticky_ovf=1 stays set. Pulse clear_ovf -> 0. Clear coincident with an overflow handshake -> stays 1.
